button_event_arbiter: RTL and testbench

- Front-end controller for all board push-buttons.
- Per button: synchronises and debounces the raw input, then turns each press into a single press event.
- A round-robin arbiter shares one event FIFO among all buttons.
- Consumers (FSMs, display logic) pop button IDs over a valid/ready interface, so no press is lost when two buttons fire together.

---
 rtl/btn_pkg.sv | 11 +
 rtl/button_event_arbiter_debouncer.sv | 67 ++++++
 rtl/button_event_arbiter.sv | 123 ++++++++++++
 tb/tb_button_event_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared button-event types and default timing constants.
package btn_pkg;
  localparam int BTN_ID_W = 4;
  localparam int DEBOUNCE_DEFAULT = 100000;
  localparam int LONG_DEFAULT = 50000000;
  typedef logic [BTN_ID_W-1:0] btn_id_t;
  typedef struct packed {
    btn_id_t id;
    logic    long;
  } btn_evt_t;
endpackage

// File: rtl/button_event_arbiter_debouncer.sv
// button_debouncer: 2-FF sync, debounce counter and press pulse for one button.
// With BTN_LONG_PRESS_EN a hold counter also emits one long-press pulse per hold.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef BTN_LONG_PRESS_EN
  , parameter int LONG_CYCLES = LONG_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
`ifdef BTN_LONG_PRESS_EN
  output logic long_o,
`endif
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic stable_q, press_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        stable_q <= ~stable_q;
        press_q <= ~stable_q;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign press_o = press_q;
`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  logic [HW-1:0] hold_q;
  logic armed_q, long_q;
  // armed_q drops after the long pulse or on release, so one long event per hold
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      armed_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_q) begin
        hold_q <= '0;
        armed_q <= 1'b1;
      end else if (!stable_q) armed_q <= 1'b0;
      else if (armed_q) begin
        if (hold_q == HW'(LONG_CYCLES - 1)) begin
          armed_q <= 1'b0;
          long_q <= 1'b1;
        end else hold_q <= hold_q + 1'b1;
      end
    end
  end
  assign long_o = long_q;
`endif
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounced press events, round-robin arbitrated into a shared FIFO.
// Define BTN_LONG_PRESS_EN to add long-press events tagged via evt_long.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int LONG_CYCLES = LONG_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_long,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int IW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (N_BTN < 2 || N_BTN > 16 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("button_event_arbiter: illegal parameter value");
  end
`ifdef BTN_LONG_PRESS_EN
  typedef btn_evt_t ent_t;
  logic [N_BTN-1:0] lng, pend_long_q, pend_long_d;
`else
  typedef btn_id_t ent_t;
`endif
  logic [N_BTN-1:0] press, ev, pend_q, pend_d;
  logic [IW-1:0] rr_q, gnt_idx;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic gnt_any, push, pop, drop, overflow_q;
  ent_t mem_q [FIFO_DEPTH];
  ent_t wr_ent;
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
      , .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_db (
      .clk(clk),
      .rst(rst),
      .raw_i(btn_raw[g]),
`ifdef BTN_LONG_PRESS_EN
      .long_o(lng[g]),
`endif
      .press_o(press[g])
    );
  end
`ifdef BTN_LONG_PRESS_EN
  assign ev = press | lng;
  assign wr_ent = {BTN_ID_W'(gnt_idx), pend_long_q[gnt_idx]};
  assign evt_id = evt_valid ? IW'(mem_q[rd_q].id) : '0;
  assign evt_long = evt_valid & mem_q[rd_q].long;
`else
  assign ev = press;
  assign wr_ent = BTN_ID_W'(gnt_idx);
  assign evt_id = evt_valid ? IW'(mem_q[rd_q]) : '0;
  assign evt_long = 1'b0;
`endif
  assign evt_valid = cnt_q != '0;
  assign overflow = overflow_q;
  assign pop = evt_valid && evt_ready;
  assign push = gnt_any && (cnt_q < (AW + 1)'(FIFO_DEPTH) || pop);
  // descending scan so the lowest offset from rr_q wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    for (int k = N_BTN - 1; k >= 0; k--)
      if (pend_q[IW'((int'(rr_q) + k) % N_BTN)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(rr_q) + k) % N_BTN);
      end
  end
  always_comb begin
    pend_d = pend_q;
`ifdef BTN_LONG_PRESS_EN
    pend_long_d = pend_long_q;
`endif
    drop = 1'b0;
    if (push) pend_d[gnt_idx] = 1'b0;
    for (int i = 0; i < N_BTN; i++)
      if (ev[i]) begin
        if (pend_q[i] && !(push && gnt_idx == IW'(i))) drop = 1'b1;
        else begin
          pend_d[i] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
          pend_long_d[i] = lng[i];
`endif
        end
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
`ifdef BTN_LONG_PRESS_EN
      pend_long_q <= '0;
`endif
      rr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
`ifdef BTN_LONG_PRESS_EN
      pend_long_q <= pend_long_d;
`endif
      if (push) rr_q <= (gnt_idx == IW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow_q <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wr_ent;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: table-driven press scenarios plus directed corner-case sequences.
module tb_button_event_arbiter;
  logic clk = 1'b0, rst = 1'b1, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic [4:0] btn_raw = '0;
  logic evt_valid, evt_long, overflow;
  logic [2:0] evt_id;
  int checks = 0, fails = 0, vcyc = 0;
  int pop_id[$], pop_long[$];
  typedef struct {
    logic [4:0] mask;
    int         hold;
    int         n;
    logic [8:0] ids;
    logic [2:0] longs;
  } vec_t;
  vec_t vecs[$];

  button_event_arbiter #(.N_BTN(5), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_long(evt_long), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] m, int h, int n, logic [8:0] ids, logic [2:0] l);
    vec_t v;
    v.mask = m; v.hold = h; v.n = n; v.ids = ids; v.longs = l;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    if (evt_valid) vcyc++;
    if (evt_valid && evt_ready) begin
      pop_id.push_back(int'(evt_id));
      pop_long.push_back(int'(evt_long));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    pop_id.delete();
    pop_long.delete();
    vcyc = 0;
  endtask

  task automatic press(input int b);
    btn_raw = 5'(1 << b);
    run(8);
    btn_raw = '0;
    run(8);
  endtask

  initial begin
    vecs.push_back(mk(5'b00100, 3, 0, 9'd0, 3'b000));
    vecs.push_back(mk(5'b00100, 10, 1, 9'd2, 3'b000));
    vecs.push_back(mk(5'b01011, 10, 3, {3'd1, 3'd0, 3'd3}, 3'b000));
`ifdef BTN_LONG_PRESS_EN
    vecs.push_back(mk(5'b00010, 40, 2, {3'd0, 3'd1, 3'd1}, 3'b010));
    vecs.push_back(mk(5'b00010, 10, 1, 9'd1, 3'b000));
`endif
    vecs.push_back(mk(5'b10000, 10, 1, 9'd4, 3'b000));
    vecs.push_back(mk(5'b01000, 10, 1, 9'd3, 3'b000));
    vecs.push_back(mk(5'b00101, 10, 2, {3'd0, 3'd2, 3'd0}, 3'b000));

    run(3);
    check("reset valid", int'(evt_valid), 0);
    check("reset id", int'(evt_id), 0);
    check("reset long", int'(evt_long), 0);
    check("reset overflow", int'(overflow), 0);
    rst = 1'b0;
    run(2);

    evt_ready = 1'b1;
    foreach (vecs[v]) begin
      logic [8:0] ids;
      logic [2:0] longs;
      clear_log();
      btn_raw = vecs[v].mask;
      run(vecs[v].hold);
      btn_raw = '0;
      run(20);
      ids = vecs[v].ids;
      longs = vecs[v].longs;
      check($sformatf("vec%0d pops", v), pop_id.size(), vecs[v].n);
      check($sformatf("vec%0d valid cycles", v), vcyc, vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++) begin
        check($sformatf("vec%0d id[%0d]", v, k), k < pop_id.size() ? pop_id[k] : -1, int'(ids[3*k +: 3]));
        check($sformatf("vec%0d long[%0d]", v, k), k < pop_long.size() ? pop_long[k] : -1, int'(longs[k]));
      end
    end

    // backpressure: FIFO fills with 0..3, button 4 waits pending, repeat press of 4 drops
    evt_ready = 1'b0;
    for (int b = 0; b < 5; b++) press(b);
    check("full valid", int'(evt_valid), 1);
    check("full head id", int'(evt_id), 0);
    check("full no overflow", int'(overflow), 0);
    press(4);
    check("drop overflow", int'(overflow), 1);
    clear_log();
    evt_ready = 1'b1;
    run(12);
    check("drain pops", pop_id.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("drain id[%0d]", k), k < pop_id.size() ? pop_id[k] : -1, k);
    check("overflow sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("overflow cleared", int'(overflow), 0);

    // exact latency: raw changes just after edge T, evt_valid rises after edge T+8
    clear_log();
    btn_raw = 5'b00001;
    run(7);
    check("latency valid early", int'(evt_valid), 0);
    step();
    check("latency valid on time", int'(evt_valid), 1);
    check("latency id", int'(evt_id), 0);
    step();
    check("latency popped", int'(evt_valid), 0);
    btn_raw = '0;
    run(15);

    // reset mid-operation discards queued events
    evt_ready = 1'b0;
    btn_raw = 5'b00111;
    run(10);
    btn_raw = '0;
    run(15);
    check("queued valid", int'(evt_valid), 1);
    check("queued head id", int'(evt_id), 1);
    rst = 1'b1;
    step();
    check("rst valid", int'(evt_valid), 0);
    check("rst id", int'(evt_id), 0);
    rst = 1'b0;
    evt_ready = 1'b1;
    clear_log();
    run(20);
    check("post-rst pops", pop_id.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
